// File: rtl/branch_sequencer_if.sv
// Instruction/flag inputs and PC/link/flag outputs between the branch sequencer and its core.
// The driver uses the master modport; the sequencer uses the slave modport.
interface branch_sequencer_if #(
  parameter int unsigned PC_W = 16
);
  logic            stall;
  logic            instr_valid;
  logic [2:0]      op_tf;
  logic [2:0]      cond;
  logic [PC_W-1:0] target;
  logic            flag_we;
  logic            alu_o;
  logic            alu_s;
  logic            alu_c;
  logic            alu_z;
  logic [PC_W-1:0] pc;
  logic            flush;
  logic            link_we;
  logic [PC_W-1:0] link_data;
  logic [3:0]      flags;

  modport master (
    output stall, instr_valid, op_tf, cond, target, flag_we,
           alu_o, alu_s, alu_c, alu_z,
    input  pc, flush, link_we, link_data, flags
  );

  modport slave (
    input  stall, instr_valid, op_tf, cond, target, flag_we,
           alu_o, alu_s, alu_c, alu_z,
    output pc, flush, link_we, link_data, flags
  );
endinterface

// File: rtl/branch_sequencer.sv
// PC sequencer: evaluates conditional branches against {O,S,C,Z} (with ALU bypass),
// redirects the PC on taken branches and inserts one flush bubble behind each.
module branch_sequencer #(
  parameter int unsigned     PC_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                reset,
  branch_sequencer_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  localparam logic [2:0] OP_JF  = 3'b000;
  localparam logic [2:0] OP_JT  = 3'b001;
  localparam logic [2:0] OP_J   = 3'b010;
  localparam logic [2:0] OP_JAL = 3'b011;
  localparam logic [2:0] OP_JR  = 3'b100;

  localparam logic [2:0] CD_TRUE    = 3'b000;
  localparam logic [2:0] CD_NEG     = 3'b001;
  localparam logic [2:0] CD_ZERO    = 3'b010;
  localparam logic [2:0] CD_CARRY   = 3'b100;
  localparam logic [2:0] CD_NEGZERO = 3'b101;
  localparam logic [2:0] CD_OVF     = 3'b111;

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [3:0]      flags_q, flags_d;
  logic            flush_q, flush_d;

  logic [3:0]      alu_flags;
  logic [3:0]      eval_flags;
  logic [PC_W-1:0] pc_inc;
  logic            sel_flag;
  logic            cond_ok;
  logic            taken;
  logic            accept;

  assign alu_flags  = {bus.alu_o, bus.alu_s, bus.alu_c, bus.alu_z};
  // Same-cycle flag producers are visible to their own branch condition.
  assign eval_flags = bus.flag_we ? alu_flags : flags_q;
  assign pc_inc     = pc_q + PC_W'(1);
  assign accept     = (state_q == ST_RUN) && bus.instr_valid && !bus.stall && !reset;

  // Condition select and taken decision; undefined encodings never branch.
  always_comb begin
    sel_flag = 1'b0;
    cond_ok  = 1'b1;
    taken    = 1'b0;
    case (bus.cond)
      CD_TRUE:    sel_flag = 1'b1;
      CD_NEG:     sel_flag = eval_flags[2];
      CD_ZERO:    sel_flag = eval_flags[0];
      CD_CARRY:   sel_flag = eval_flags[1];
      CD_NEGZERO: sel_flag = eval_flags[2] & eval_flags[0];
      CD_OVF:     sel_flag = eval_flags[3];
      default:    cond_ok  = 1'b0;
    endcase
    case (bus.op_tf)
      OP_JF:               taken = cond_ok & ~sel_flag;
      OP_JT:               taken = cond_ok &  sel_flag;
      OP_J, OP_JAL, OP_JR: taken = 1'b1;
      default:             taken = 1'b0;
    endcase
  end

  // Next-state logic; stall leaves every register at its current value.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    flags_d = flags_q;
    flush_d = flush_q;
    if (!bus.stall) begin
      case (state_q)
        ST_BOOT: begin
          state_d = ST_RUN;
          flush_d = 1'b0;
        end
        ST_RUN: begin
          flush_d = 1'b0;
          if (bus.instr_valid) begin
            if (bus.flag_we) flags_d = alu_flags;
            if (taken) begin
              pc_d    = bus.target;
              flush_d = 1'b1;
              state_d = ST_FLUSH;
            end else begin
              pc_d = pc_inc;
            end
          end
        end
        ST_FLUSH: begin
          pc_d    = pc_inc;
          flush_d = 1'b0;
          state_d = ST_RUN;
        end
        default: begin
          state_d = ST_BOOT;
          flush_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_PC;
      flags_q <= 4'b0000;
      flush_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      flags_q <= flags_d;
      flush_q <= flush_d;
    end
  end

  assign bus.pc        = pc_q;
  assign bus.flush     = flush_q;
  assign bus.flags     = flags_q;
  // Link write happens in the jal's own execution cycle.
  assign bus.link_we   = accept && (bus.op_tf == OP_JAL);
  assign bus.link_data = pc_inc;

endmodule

// File: tb/tb_branch_sequencer.sv
// Self-checking bench for branch_sequencer: directed scenarios plus randomized
// traffic compared against a cycle-level behavioural model.
module tb_branch_sequencer;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  branch_sequencer_if #(.PC_W(16)) bif();

  branch_sequencer #(.PC_W(16), .RESET_PC(16'h0000)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: boot pending / in branch shadow, plus architectural pc and flags.
  logic [15:0] m_pc;
  logic [3:0]  m_flags;
  logic        m_boot;
  logic        m_shadow;
  logic        exp_link_we;
  logic [15:0] exp_link_data;
  logic        obs_link_we;
  logic [15:0] obs_link_data;

  function automatic logic m_taken(input logic [2:0] op, input logic [2:0] cd,
                                   input logic fwe, input logic [3:0] alu);
    logic [3:0] f;
    logic       s;
    logic       ok;
    f  = fwe ? alu : m_flags;
    ok = 1'b1;
    s  = 1'b0;
    case (cd)
      3'd0: s = 1'b1;
      3'd1: s = f[2];
      3'd2: s = f[0];
      3'd4: s = f[1];
      3'd5: s = f[2] & f[0];
      3'd7: s = f[3];
      default: ok = 1'b0;
    endcase
    case (op)
      3'd0: return ok && !s;
      3'd1: return ok && s;
      3'd2, 3'd3, 3'd4: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Drive one cycle, sample the combinational link outputs, advance model and clock.
  task automatic cyc(input logic rst, input logic st, input logic v,
                     input logic [2:0] op, input logic [2:0] cd,
                     input logic [15:0] tgt, input logic fwe, input logic [3:0] alu);
    logic accepted;
    reset           = rst;
    bif.stall       = st;
    bif.instr_valid = v;
    bif.op_tf       = op;
    bif.cond        = cd;
    bif.target      = tgt;
    bif.flag_we     = fwe;
    {bif.alu_o, bif.alu_s, bif.alu_c, bif.alu_z} = alu;
    #1;
    obs_link_we   = bif.link_we;
    obs_link_data = bif.link_data;
    accepted      = !rst && !st && !m_boot && !m_shadow && v;
    exp_link_we   = accepted && (op == 3'd3);
    exp_link_data = m_pc + 16'd1;
    if (rst) begin
      m_pc = 16'h0000; m_flags = 4'b0000; m_boot = 1'b1; m_shadow = 1'b0;
    end else if (!st) begin
      if (m_boot) m_boot = 1'b0;
      else if (m_shadow) begin m_pc = m_pc + 16'd1; m_shadow = 1'b0; end
      else if (v) begin
        if (m_taken(op, cd, fwe, alu)) begin m_pc = tgt; m_shadow = 1'b1; end
        else m_pc = m_pc + 16'd1;
        if (fwe) m_flags = alu;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic nop_cyc();
    cyc(1'b0, 1'b0, 1'b1, 3'b111, 3'b000, 16'h0000, 1'b0, 4'b0000);
  endtask

  task automatic do_reset();
    cyc(1'b1, 1'b0, 1'b0, 3'b111, 3'b000, 16'h0000, 1'b0, 4'b0000);
    cyc(1'b1, 1'b0, 1'b0, 3'b111, 3'b000, 16'h0000, 1'b0, 4'b0000);
    cyc(1'b0, 1'b0, 1'b0, 3'b111, 3'b000, 16'h0000, 1'b0, 4'b0000);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      cyc(1'b1, 1'($urandom_range(0, 1)), 1'b1, 3'b011, 3'b000, 16'h1234, 1'b1, 4'b1111);
      n_tests++;
      if (bif.pc !== 16'h0000 || bif.flush !== 1'b0 || bif.flags !== 4'b0000 || obs_link_we !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_state: pc=%h flush=%b flags=%b link_we=%b, expected 0000/0/0000/0",
                 bif.pc, bif.flush, bif.flags, obs_link_we);
      end
    end
    nop_cyc();
    n_tests++;
    if (bif.pc !== 16'h0000 || obs_link_we !== 1'b0) begin
      n_fail++;
      $display("FAIL boot_hold: pc=%h link_we=%b, expected 0000/0", bif.pc, obs_link_we);
    end
    for (int i = 1; i <= 3; i++) begin
      nop_cyc();
      n_tests++;
      if (bif.pc !== 16'(i) || bif.flush !== 1'b0) begin
        n_fail++;
        $display("FAIL boot_count: pc=%h flush=%b, expected %h/0", bif.pc, bif.flush, 16'(i));
      end
    end
  endtask

  task automatic test_jt_bypass();
    do_reset();
    cyc(1'b0, 1'b0, 1'b1, 3'b001, 3'b010, 16'h0040, 1'b1, 4'b0001);
    n_tests++;
    if (bif.pc !== 16'h0040 || bif.flush !== 1'b1 || bif.flags !== 4'b0001 || obs_link_we !== 1'b0) begin
      n_fail++;
      $display("FAIL jt_bypass: pc=%h flush=%b flags=%b link=%b, expected 0040/1/0001/0",
               bif.pc, bif.flush, bif.flags, obs_link_we);
    end
    cyc(1'b0, 1'b0, 1'b1, 3'b010, 3'b000, 16'h0999, 1'b1, 4'b1110);
    n_tests++;
    if (bif.pc !== 16'h0041 || bif.flush !== 1'b0 || bif.flags !== 4'b0001) begin
      n_fail++;
      $display("FAIL jt_shadow: pc=%h flush=%b flags=%b, expected 0041/0/0001",
               bif.pc, bif.flush, bif.flags);
    end
  endtask

  task automatic test_jf_carry();
    do_reset();
    cyc(1'b0, 1'b0, 1'b1, 3'b111, 3'b000, 16'h0000, 1'b1, 4'b0010);
    for (int i = 0; i < 4; i++) nop_cyc();
    n_tests++;
    if (bif.pc !== 16'h0005 || bif.flags !== 4'b0010) begin
      n_fail++;
      $display("FAIL jf_setup: pc=%h flags=%b, expected 0005/0010", bif.pc, bif.flags);
    end
    cyc(1'b0, 1'b0, 1'b1, 3'b000, 3'b100, 16'h0099, 1'b0, 4'b0000);
    n_tests++;
    if (bif.pc !== 16'h0006 || bif.flush !== 1'b0) begin
      n_fail++;
      $display("FAIL jf_carry_nt: pc=%h flush=%b, expected 0006/0", bif.pc, bif.flush);
    end
    // Bypassed C=0 overrides the stored C=1, so jf.carry is taken.
    cyc(1'b0, 1'b0, 1'b1, 3'b000, 3'b100, 16'h0020, 1'b1, 4'b0000);
    n_tests++;
    if (bif.pc !== 16'h0020 || bif.flush !== 1'b1 || bif.flags !== 4'b0000) begin
      n_fail++;
      $display("FAIL jf_carry_bypass: pc=%h flush=%b flags=%b, expected 0020/1/0000",
               bif.pc, bif.flush, bif.flags);
    end
  endtask

  task automatic test_jal();
    do_reset();
    cyc(1'b0, 1'b0, 1'b1, 3'b010, 3'b000, 16'h000F, 1'b0, 4'b0000);
    nop_cyc();
    n_tests++;
    if (bif.pc !== 16'h0010) begin
      n_fail++;
      $display("FAIL jal_setup: pc=%h, expected 0010", bif.pc);
    end
    cyc(1'b0, 1'b0, 1'b1, 3'b011, 3'b000, 16'h0080, 1'b0, 4'b0000);
    n_tests++;
    if (obs_link_we !== 1'b1 || obs_link_data !== 16'h0011 || bif.pc !== 16'h0080 || bif.flush !== 1'b1) begin
      n_fail++;
      $display("FAIL jal_exec: link_we=%b link_data=%h pc=%h flush=%b, expected 1/0011/0080/1",
               obs_link_we, obs_link_data, bif.pc, bif.flush);
    end
    cyc(1'b0, 1'b0, 1'b1, 3'b011, 3'b000, 16'h0200, 1'b0, 4'b0000);
    n_tests++;
    if (obs_link_we !== 1'b0 || bif.pc !== 16'h0081 || bif.flush !== 1'b0) begin
      n_fail++;
      $display("FAIL jal_shadow: link_we=%b pc=%h flush=%b, expected 0/0081/0",
               obs_link_we, bif.pc, bif.flush);
    end
  endtask

  task automatic test_wrap_stall();
    do_reset();
    cyc(1'b0, 1'b0, 1'b1, 3'b100, 3'b000, 16'hFFFE, 1'b0, 4'b0000);
    nop_cyc();
    n_tests++;
    if (bif.pc !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL wrap_setup: pc=%h, expected ffff", bif.pc);
    end
    cyc(1'b0, 1'b0, 1'b1, 3'b111, 3'b000, 16'h0000, 1'b1, 4'b1010);
    n_tests++;
    if (bif.pc !== 16'h0000 || bif.flags !== 4'b1010) begin
      n_fail++;
      $display("FAIL wrap: pc=%h flags=%b, expected 0000/1010", bif.pc, bif.flags);
    end
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b1, 1'b1, (i == 1) ? 3'b011 : 3'b010, 3'b000, 16'h1234, 1'b1, 4'b0101);
      n_tests++;
      if (bif.pc !== 16'h0000 || bif.flags !== 4'b1010 || bif.flush !== 1'b0 || obs_link_we !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_hold: pc=%h flags=%b flush=%b link=%b, expected 0000/1010/0/0",
                 bif.pc, bif.flags, bif.flush, obs_link_we);
      end
    end
    cyc(1'b0, 1'b0, 1'b1, 3'b010, 3'b000, 16'h1234, 1'b0, 4'b0000);
    cyc(1'b0, 1'b1, 1'b0, 3'b111, 3'b000, 16'h0000, 1'b0, 4'b0000);
    n_tests++;
    if (bif.pc !== 16'h1234 || bif.flush !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_in_flush: pc=%h flush=%b, expected 1234/1", bif.pc, bif.flush);
    end
    nop_cyc();
    n_tests++;
    if (bif.pc !== 16'h1235 || bif.flush !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_release: pc=%h flush=%b, expected 1235/0", bif.pc, bif.flush);
    end
  endtask

  task automatic test_undefined();
    logic [2:0] ops [4];
    logic [2:0] cds [4];
    ops = '{3'b101, 3'b110, 3'b001, 3'b000};
    cds = '{3'b000, 3'b000, 3'b011, 3'b110};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 1'b0, 1'b1, ops[i], cds[i], 16'h0777, 1'b0, 4'b1111);
      n_tests++;
      if (bif.pc !== 16'(i + 1) || bif.flush !== 1'b0 || obs_link_we !== 1'b0) begin
        n_fail++;
        $display("FAIL undef_enc op=%b cond=%b: pc=%h flush=%b link=%b, expected %h/0/0",
                 ops[i], cds[i], bif.pc, bif.flush, obs_link_we, 16'(i + 1));
      end
    end
    cyc(1'b0, 1'b0, 1'b1, 3'b010, 3'b000, 16'h0300, 1'b0, 4'b0000);
    cyc(1'b1, 1'b0, 1'b1, 3'b111, 3'b000, 16'h0000, 1'b0, 4'b0000);
    n_tests++;
    if (bif.pc !== 16'h0000 || bif.flush !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_flush: pc=%h flush=%b, expected 0000/0", bif.pc, bif.flush);
    end
    cyc(1'b0, 1'b0, 1'b1, 3'b111, 3'b000, 16'h0000, 1'b0, 4'b0000);
    n_tests++;
    if (bif.pc !== 16'h0000 || bif.flush !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_boot: pc=%h flush=%b, expected 0000/0", bif.pc, bif.flush);
    end
  endtask

  task automatic test_random();
    logic       rst, st, v, fwe;
    logic [2:0] op, cd;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 59) == 0);
      st  = ($urandom_range(0, 5) == 0);
      v   = ($urandom_range(0, 3) != 0);
      fwe = 1'($urandom_range(0, 1));
      op  = 3'($urandom_range(0, 7));
      cd  = 3'($urandom_range(0, 7));
      if (op >= 3'd2 && op <= 3'd4 && (cd == 3'd3 || cd == 3'd6)) cd = 3'd0;
      cyc(rst, st, v, op, cd, 16'($urandom), fwe, 4'($urandom_range(0, 15)));
      n_tests++;
      if (bif.pc !== m_pc || bif.flush !== m_shadow || bif.flags !== m_flags || obs_link_we !== exp_link_we
          || (exp_link_we && obs_link_data !== exp_link_data)) begin
        n_fail++;
        $display("FAIL random[%0d]: pc=%h flush=%b flags=%b link=%b/%h, expected %h/%b/%b/%b/%h",
                 i, bif.pc, bif.flush, bif.flags, obs_link_we, obs_link_data,
                 m_pc, m_shadow, m_flags, exp_link_we, exp_link_data);
      end
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    m_pc = '0; m_flags = '0; m_boot = 1'b1; m_shadow = 1'b0;
    test_reset();
    test_jt_bypass();
    test_jf_carry();
    test_jal();
    test_wrap_stall();
    test_undefined();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/branch_sequencer.md
BRANCH_SEQUENCER -- requirements
Module: branch_sequencer

Interface
REQ-001 SHALL have parameter PC_W, default 16, PC and target width.
REQ-002 SHALL have parameter RESET_PC, default 0, PC value loaded on reset.
REQ-003 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port stall  input  1  hold all state (PC, flags, FSM) this cycle.
REQ-006 SHALL have port instr_valid  input  1  op_tf/cond/target describe a valid instruction this cycle.
REQ-007 SHALL have port op_tf  input  3  000 jf, 001 jt, 010 j, 011 jal, 100 jr, 111 non-branch.
REQ-008 SHALL have port cond  input  3  000 true, 001 neg, 010 zero, 100 carry, 101 negzero, 111 overflow.
REQ-009 SHALL have port target  input  PC_W  branch destination (ALU result or register for jr).
REQ-010 SHALL have port flag_we  input  1  current instruction updates flags.
REQ-011 SHALL have port alu_o, alu_s, alu_c, alu_z  input  1 each  flags produced by ALU this cycle.
REQ-012 SHALL have port pc  output  PC_W  registered program counter.
REQ-013 SHALL have port flush  output  1  registered; kill the instruction fetched in the branch shadow.
REQ-014 SHALL have port link_we  output  1  one-cycle pulse, write link_data to link register.
REQ-015 SHALL have port link_data  output  PC_W  return address, pc+1 of the jal.
REQ-016 SHALL have port flags  output  4  registered {O,S,C,Z}.

Function
REQ-017 SHALL hold FSM states BOOT, RUN, FLUSH.
REQ-018 SHALL go BOOT->RUN one cycle after reset deassertion, pc held at RESET_PC and no instruction accepted in BOOT.
REQ-019 SHALL ignore instr_valid while in BOOT or FLUSH; such instructions do not update flags or pc.
REQ-020 SHALL, in RUN with instr_valid and not stall, evaluate taken: jf taken when selected flag is 0; jt taken when selected flag is 1; j, jal, jr always taken; 111 never taken.
REQ-021 SHALL select flag by cond: true->constant 1 (jf never taken, jt always), neg->S, zero->Z, carry->C, negzero->S&Z, overflow->O.
REQ-022 SHALL treat undefined cond (011, 110) and undefined op_tf (101, 110) as not taken, with no flush or link.
REQ-023 SHALL evaluate conditions against the live ALU flags when flag_we is 1 in the same cycle (bypass), else against the flags register.
REQ-024 SHALL, on taken, load pc <= target, assert flush for the next cycle, enter FLUSH for exactly one cycle, then return to RUN.
REQ-025 SHALL, on not taken or non-branch, load pc <= pc+1 (mod 2^PC_W, all-ones wraps to 0), flush=0, stay RUN.
REQ-026 SHALL, in FLUSH with no stall, load pc <= pc+1 and return to RUN.
REQ-027 SHALL, for jal, pulse link_we for the execution cycle (combinational with acceptance) with link_data = pc+1 (wrapped).
REQ-028 SHALL latch flags <= {alu_o,alu_s,alu_c,alu_z} when instruction accepted with flag_we=1, including when it is also a branch.
REQ-029 SHALL, when stall=1, hold pc, flags, FSM state and flush, and drive link_we=0; stall has priority over instr_valid.
REQ-030 SHALL apply taken-branch latency: target visible on pc one cycle after acceptance; one bubble (flush) per taken branch.

Reset
REQ-031 SHALL on reset=1 at a clock edge set pc=RESET_PC, flags=0000, flush=0, state=BOOT, regardless of stall or instr_valid.
REQ-032 SHALL drive link_we=0 while reset=1.
REQ-033 SHALL abort any pending FLUSH on reset; no flush pulse after reset.

Verification
REQ-034 SHALL verify reset/boot: reset 2 cycles, release -> pc=0 for BOOT cycle, then 1,2,3 with instr_valid, op_tf=111.
REQ-035 SHALL verify jt.zero bypass: flags=0000, instr with flag_we=1, alu_z=1, op_tf=001, cond=010, target=0x40 -> next pc=0x40, flush=1, flags=0001.
REQ-036 SHALL verify jf.carry not taken: flags C=1, op_tf=000, cond=100 at pc=5 -> pc=6, flush=0.
REQ-037 SHALL verify jal at pc=0x10, target=0x80 -> link_we=1, link_data=0x11; next pc=0x80; instruction in FLUSH cycle ignored; then pc=0x81.
REQ-038 SHALL verify wrap and stall: pc=0xFFFF non-branch -> pc=0; stall=1 for 3 cycles with j pending -> pc, flags unchanged, no flush, link_we=0.
REQ-039 SHALL verify undefined encodings and reset mid-FLUSH: op_tf=101 or cond=011 -> pc+1, no flush; reset during FLUSH -> pc=RESET_PC, flush=0.
